// File: rtl/monolith_concrete_inv_if.sv
// rtl/monolith_concrete_inv_if.sv - handshake and vector bus for the circulant inverse multiplier
interface monolith_concrete_inv_if #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] state_in  [0:STATE_SIZE-1];
    logic [WORD_WIDTH-1:0] inv_row   [0:STATE_SIZE-1];
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] state_out [0:STATE_SIZE-1];

    modport master (
        output in_valid, state_in, inv_row, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, inv_row, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/monolith_concrete_inv.sv
// rtl/monolith_concrete_inv.sv - serial circulant matrix-vector multiply modulo 2^W-1
module monolith_concrete_inv #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    monolith_concrete_inv_if.slave bus
);
    localparam int W  = WORD_WIDTH;
    localparam int PW = 2 * WORD_WIDTH;
    localparam int CW = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
    localparam logic [W-1:0]  P    = {W{1'b1}};
    localparam logic [CW-1:0] LAST = CW'(STATE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  x_r [0:STATE_SIZE-1];
    logic [W-1:0]  r_r [0:STATE_SIZE-1];
    logic [W-1:0]  acc;
    logic [CW-1:0] i_cnt;
    logic [CW-1:0] j_cnt;

    logic [CW-1:0] idx;
    logic [W-1:0]  r_sel;
    logic [W-1:0]  x_sel;
    logic [PW-1:0] mac;
    logic [W:0]    fold;
    logic [W-1:0]  folded;
    logic [W-1:0]  acc_next;

    // A word equal to p is the second encoding of zero; store it as zero.
    function automatic logic [W-1:0] canon(input logic [W-1:0] w);
        return (w == P) ? '0 : w;
    endfunction

    // Row i uses r rotated right by i: coefficient index (j - i) mod N without a wider intermediate.
    always_comb begin
        idx = '0;
        if (j_cnt >= i_cnt) begin
            idx = j_cnt - i_cnt;
        end else begin
            idx = j_cnt + (LAST - i_cnt) + CW'(1);
        end
    end

    assign r_sel = r_r[idx];
    assign x_sel = x_r[j_cnt];

    // acc + r*x stays below 2^(2W) because acc and both operands are canonical.
    assign mac = (PW'(r_sel) * PW'(x_sel)) + PW'(acc);

    // Mersenne fold: 2^W == 1 mod p, so lo + hi, then fold the carry back in and map p to 0.
    assign fold     = {1'b0, mac[W-1:0]} + {1'b0, mac[PW-1:W]};
    assign folded   = fold[W-1:0] + {{(W-1){1'b0}}, fold[W]};
    assign acc_next = (folded == P) ? '0 : folded;

    // Control FSM, MAC datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            acc           <= '0;
            i_cnt         <= '0;
            j_cnt         <= '0;
            for (int k = 0; k < STATE_SIZE; k++) begin
                x_r[k]           <= '0;
                r_r[k]           <= '0;
                bus.state_out[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < STATE_SIZE; k++) begin
                            x_r[k] <= canon(bus.state_in[k]);
                            r_r[k] <= canon(bus.inv_row[k]);
                        end
                        acc          <= '0;
                        i_cnt        <= '0;
                        j_cnt        <= '0;
                        state        <= BUSY;
                        bus.in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    if (j_cnt == LAST) begin
                        bus.state_out[i_cnt] <= acc_next;
                        acc                  <= '0;
                        j_cnt                <= '0;
                        if (i_cnt == LAST) begin
                            i_cnt         <= '0;
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                        end else begin
                            i_cnt <= i_cnt + CW'(1);
                        end
                    end else begin
                        acc   <= acc_next;
                        j_cnt <= j_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_monolith_concrete_inv.sv
// tb/tb_monolith_concrete_inv.sv - directed self-checking bench for monolith_concrete_inv
module tb_monolith_concrete_inv;
    localparam int WW = 31;
    localparam int N  = 16;
    localparam logic [WW-1:0] PM = 31'h7FFF_FFFF;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    logic [WW-1:0] rv [0:N-1];
    logic [WW-1:0] xv [0:N-1];
    logic [WW-1:0] ev [0:N-1];

    monolith_concrete_inv_if #(.WORD_WIDTH(WW), .STATE_SIZE(N)) bus ();

    monolith_concrete_inv #(.WORD_WIDTH(WW), .STATE_SIZE(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < N; k++) begin
            bus.state_in[k] = xv[k];
            bus.inv_row[k]  = rv[k];
        end
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        cnt = 0;
        while (cnt < 400 && bus.out_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd256);
    endtask

    task automatic check_vec(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_y%0d", tag, k), 32'(bus.state_out[k]), 32'(ev[k]));
        end
    endtask

    task automatic release_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic set_ident_ramp();
        for (int k = 0; k < N; k++) begin
            rv[k] = (k == 0) ? 31'd1 : 31'd0;
            xv[k] = 31'(k + 1);
            ev[k] = 31'(k + 1);
        end
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            bus.state_in[k] = '0;
            bus.inv_row[k]  = '0;
        end

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y0", 32'(bus.state_out[0]), 32'd0);
        check("rst_y15", 32'(bus.state_out[15]), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Identity row, ramp input; out_valid lasts exactly one cycle
        bus.out_ready = 1'b1;
        set_ident_ramp();
        accept("t1");
        wait_done("t1");
        check_vec("t1");
        release_check("t1");

        // r[1] = 1: y[i] = x[(i+1) mod 16]
        for (int k = 0; k < N; k++) begin
            rv[k] = (k == 1) ? 31'd1 : 31'd0;
            xv[k] = 31'(32'h100 + k);
        end
        for (int k = 0; k < 15; k++) ev[k] = 31'(32'h100 + k + 1);
        ev[15] = 31'h100;
        accept("t2");
        wait_done("t2");
        check_vec("t2");
        release_check("t2");

        // All r = p-1, all x = 1: sixteen copies of -1
        for (int k = 0; k < N; k++) begin
            rv[k] = 31'h7FFF_FFFE;
            xv[k] = 31'd1;
            ev[k] = 31'h7FFF_FFEF;
        end
        accept("t3");
        wait_done("t3");
        check_vec("t3");
        release_check("t3");

        // x = p is zero
        for (int k = 0; k < N; k++) begin
            rv[k] = (k == 0) ? 31'd1 : 31'd0;
            xv[k] = PM;
            ev[k] = 31'd0;
        end
        accept("t4a");
        wait_done("t4a");
        check_vec("t4a");
        release_check("t4a");

        // x = p-1 stays p-1
        for (int k = 0; k < N; k++) begin
            xv[k] = 31'h7FFF_FFFE;
            ev[k] = 31'h7FFF_FFFE;
        end
        accept("t4b");
        wait_done("t4b");
        check_vec("t4b");
        release_check("t4b");

        // Backpressure: r[0] = 2, ramp input, out_ready low for 10 cycles, in_valid ignored
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            rv[k] = (k == 0) ? 31'd2 : 31'd0;
            xv[k] = 31'(k + 1);
            ev[k] = 31'(2 * (k + 1));
        end
        accept("t5");
        wait_done("t5");
        check_vec("t5");
        for (int k = 0; k < N; k++) begin
            bus.state_in[k] = 31'h55;
            bus.inv_row[k]  = 31'h1;
        end
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("t5_hold_valid%0d", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("t5_hold_ready%0d", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("t5_hold_y3_%0d", c), 32'(bus.state_out[3]), 32'd8);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        release_check("t5");
        check_vec("t5_after");

        // Reset 100 cycles into BUSY, then a fresh operation
        set_ident_ramp();
        accept("t6");
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("t6_rst_y0", 32'(bus.state_out[0]), 32'd0);
        check("t6_rst_y15", 32'(bus.state_out[15]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        accept("t6b");
        wait_done("t6b");
        check_vec("t6b");
        release_check("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/monolith_concrete_inv.md
MONOLITH_CONCRETE_INV -- requirements
Module: monolith_concrete_inv

Interface
REQ-001 Parameter WORD_WIDTH, default 31, SHALL set the word width; modulus p = 2^WORD_WIDTH - 1.
REQ-002 Parameter STATE_SIZE, default 16, SHALL set the vector length N.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  state_in and inv_row are valid.
REQ-006 in_ready  output  1  block accepts a new vector.
REQ-007 state_in  input  WORD_WIDTH x [0:STATE_SIZE-1]  input vector x.
REQ-008 inv_row  input  WORD_WIDTH x [0:STATE_SIZE-1]  first row r of the inverse circulant matrix.
REQ-009 out_valid  output  1  state_out holds a complete result.
REQ-010 out_ready  input  1  downstream consumes state_out.
REQ-011 state_out  output  WORD_WIDTH x [0:STATE_SIZE-1]  result vector y.

Function
REQ-012 Result SHALL be y[i] = sum over j of r[(j - i) mod N] * x[j] mod p, for i, j in 0..N-1 (row i is r rotated right by i).
REQ-013 FSM SHALL have states IDLE, BUSY and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 On an edge with in_valid && in_ready, the block SHALL register state_in and inv_row, clear row counter i, column counter j and the accumulator, and enter BUSY.
REQ-015 In BUSY, each edge SHALL perform exactly one MAC: acc <= (acc + r[(j - i) mod N] * x[j]) mod p.
REQ-016 When j == N-1, the block SHALL write the completed sum into state_out[i], clear acc, wrap j to 0 and increment i.
REQ-017 The edge completing i == N-1, j == N-1 SHALL enter DONE, so out_valid rises exactly N*N edges after the accepting edge (256 for defaults).
REQ-018 In DONE, state_out SHALL hold stable until an edge with out_ready == 1; that edge SHALL return the block to IDLE.
REQ-019 in_ready is low in DONE, so acceptance and release never share a cycle; minimum issue interval is N*N + 2 cycles.
REQ-020 in_valid outside IDLE and out_ready outside DONE SHALL be ignored.
REQ-021 Product width SHALL be 2*WORD_WIDTH; reduction SHALL use the Mersenne fold (lo + hi, then a conditional subtract of p).
REQ-022 Every state_out word SHALL be canonical in [0, p-1]; an input word equal to p SHALL be treated as 0.
REQ-023 state_out words not yet written in the current operation SHALL retain their previous values; state_out is meaningful only while out_valid == 1.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, in_ready = 1, out_valid = 0, state_out all zero, and clear i, j, acc and the registered vectors.
REQ-025 Reset during BUSY or DONE SHALL discard the partial or held result; the first accepted vector after release SHALL be processed from scratch.

Verification
REQ-026 inv_row = [1,0,...,0], x[j] = j+1, out_ready = 1 -> y[j] = j+1; out_valid high exactly 256 edges after acceptance, for one cycle.
REQ-027 inv_row with r[1] = 1, all others 0; x[j] = 0x100+j -> y[i] = x[(i+1) mod 16], e.g. y[15] = 0x100.
REQ-028 All r = 0x7FFFFFFE, all x = 1 -> every y[i] = 0x7FFFFFEF (-16 mod p).
REQ-029 All x = 0x7FFFFFFF, identity row -> all y = 0; all x = 0x7FFFFFFE, identity row -> all y = 0x7FFFFFFE.
REQ-030 Hold out_ready = 0 for 10 cycles after out_valid -> state_out stable, in_ready = 0, in_valid ignored; raise out_ready -> IDLE on the next edge, in_ready = 1.
REQ-031 Assert reset 100 cycles into BUSY -> out_valid = 0, state_out = 0, in_ready = 1 immediately; next vector (REQ-026 stimulus) -> correct result after 256 edges.
